// File: rtl/led_matrix_scanner_pkg.sv
// led_scan_pkg: glyph geometry, blank code and scanner FSM encoding shared by led_matrix_scanner
package led_scan_pkg;
   localparam int GLYPH_ROWS = 7;
   localparam int GLYPH_COLS = 7;
   localparam logic [3:0] BLANK_CODE = 4'hF;
   typedef enum logic [1:0] {ST_FETCH, ST_SHIFT, ST_LATCH, ST_DWELL} state_t;
endpackage

// File: rtl/digit_5x7_rom.sv
// digit_5x7_rom: one row of a 5x7 decimal glyph centred in a 7-pixel field; codes 10-15 are blank
module digit_5x7_rom
   import led_scan_pkg::*;
(
   input  logic [3:0]            i_code,
   input  logic [2:0]            i_row,
   output logic [GLYPH_COLS-1:0] o_pixels
);
   logic [34:0] w_glyph;
   logic [34:0] w_shift;
   // glyph rows are packed top row first, five pixels each
   always_comb begin
      case (i_code)
         4'd0:    w_glyph = 35'b01110_10001_10011_10101_11001_10001_01110;
         4'd1:    w_glyph = 35'b00100_01100_00100_00100_00100_00100_01110;
         4'd2:    w_glyph = 35'b01110_10001_00001_00010_00100_01000_11111;
         4'd3:    w_glyph = 35'b01110_10001_00001_00110_00001_10001_01110;
         4'd4:    w_glyph = 35'b00010_00110_01010_10010_11111_00010_00010;
         4'd5:    w_glyph = 35'b11111_10000_11110_00001_00001_10001_01110;
         4'd6:    w_glyph = 35'b00110_01000_10000_11110_10001_10001_01110;
         4'd7:    w_glyph = 35'b11111_00001_00010_00100_01000_01000_01000;
         4'd8:    w_glyph = 35'b01110_10001_10001_01110_10001_10001_01110;
         4'd9:    w_glyph = 35'b01110_10001_10001_01111_00001_00010_01100;
         default: w_glyph = '0;
      endcase
      w_shift  = w_glyph << (5 * i_row);
      o_pixels = {1'b0, w_shift[34:30], 1'b0};
   end
endmodule

// File: rtl/led_matrix_scanner_hc595_shifter.sv
// hc595_shifter: MSB-first serialiser for a 74HC595 chain, CLK_DIV-paced, followed by a CLK_DIV-cycle latch pulse
module hc595_shifter #(
   parameter int WIDTH   = 28,
   parameter int CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_ser_data,
   output logic             o_ser_clk,
   output logic             o_ser_latch,
   output logic             o_shift_done,
   output logic             o_done
);
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   logic [WIDTH-1:0] r_sh;
   logic [DW-1:0]    r_div;
   logic [BW-1:0]    r_bit;
   logic             r_active;
   logic             r_clk;
   logic             r_latch;
   logic             w_tick;
   assign w_tick       = (r_div == DIV_LAST);
   assign o_shift_done = r_active && r_clk && w_tick && (r_bit == BIT_LAST);
   assign o_done       = r_latch && w_tick;
   assign o_ser_data   = r_active && r_sh[WIDTH-1];
   assign o_ser_clk    = r_clk;
   assign o_ser_latch  = r_latch;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh     <= '0;
         r_div    <= '0;
         r_bit    <= '0;
         r_active <= 1'b0;
         r_clk    <= 1'b0;
         r_latch  <= 1'b0;
      end else if (i_load) begin
         r_sh     <= i_data;
         r_div    <= '0;
         r_bit    <= '0;
         r_active <= 1'b1;
         r_clk    <= 1'b0;
         r_latch  <= 1'b0;
      end else begin
         r_div <= (w_tick || !(r_active || r_latch)) ? '0 : r_div + 1'b1;
         // data advances on the falling shift clock so it is stable across each high phase
         if (r_active && w_tick) begin
            r_clk <= !r_clk;
            if (r_clk) begin
               r_sh  <= r_sh << 1;
               r_bit <= r_bit + 1'b1;
            end
            if (o_shift_done) begin
               r_active <= 1'b0;
               r_latch  <= 1'b1;
            end
         end
         if (o_done) r_latch <= 1'b0;
      end
   end
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-multiplexed 7-row dot-matrix digit driver feeding a 74HC595 column chain.
// Optional LEDSCAN_LEADING_ZERO_BLANK_EN blanks zeros left of the most significant non-zero digit.
module led_matrix_scanner
   import led_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_DIV    = 4,
   parameter int ROW_DWELL  = 2000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    load,
   output logic                    ser_data,
   output logic                    ser_clk,
   output logic                    ser_latch,
   output logic [6:0]              row_sel,
   output logic                    frame_done
);
   localparam int NB = GLYPH_COLS * NUM_DIGITS;
   localparam int DW = $clog2(ROW_DWELL + 1);
   localparam logic [2:0] LAST_ROW = 3'(GLYPH_ROWS - 1);
   state_t                  r_state;
   state_t                  w_next;
   logic [2:0]              r_row;
   logic [4*NUM_DIGITS-1:0] r_pend;
   logic                    r_pend_valid;
   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [DW-1:0]           r_dwell;
   logic [4*NUM_DIGITS-1:0] w_shadow;
   logic [3:0]              w_code [NUM_DIGITS];
   logic [NB-1:0]           w_pattern;
   logic                    w_fetch;
   logic                    w_row0_fetch;
   logic                    w_dwell_end;
   logic                    w_shift_done;
   logic                    w_done;
`ifdef LEDSCAN_LEADING_ZERO_BLANK_EN
   logic                    w_lead;
`endif
   assign w_fetch      = (r_state == ST_FETCH);
   assign w_row0_fetch = w_fetch && (r_row == 3'd0);
   assign w_dwell_end  = (r_state == ST_DWELL) && (r_dwell == DW'(ROW_DWELL - 1));
   // a load arriving in the row-0 fetch itself overrides whatever is pending
   assign w_shadow     = !w_row0_fetch ? r_shadow : load ? digits_in : r_pend_valid ? r_pend : r_shadow;
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_FETCH;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_FETCH: w_next = ST_SHIFT;
         ST_SHIFT: w_next = w_shift_done ? ST_LATCH : ST_SHIFT;
         ST_LATCH: w_next = w_done ? ST_DWELL : ST_LATCH;
         default:  w_next = w_dwell_end ? ST_FETCH : ST_DWELL;
      endcase
      row_sel    = (r_state == ST_DWELL) ? (7'b1 << r_row) : 7'b0;
      frame_done = w_dwell_end && (r_row == LAST_ROW);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row        <= '0;
         r_pend       <= '0;
         r_pend_valid <= 1'b0;
         r_shadow     <= '0;
         r_dwell      <= '0;
      end else begin
         r_shadow     <= w_shadow;
         r_pend       <= load ? digits_in : r_pend;
         r_pend_valid <= w_row0_fetch ? 1'b0 : (load || r_pend_valid);
         r_dwell      <= ((r_state == ST_DWELL) && !w_dwell_end) ? r_dwell + 1'b1 : '0;
         if (w_dwell_end) r_row <= (r_row == LAST_ROW) ? 3'd0 : r_row + 1'b1;
      end
   end
   always_comb begin
`ifdef LEDSCAN_LEADING_ZERO_BLANK_EN
      w_lead = 1'b1;
`endif
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef LEDSCAN_LEADING_ZERO_BLANK_EN
         w_lead    = w_lead && (w_shadow[4*i +: 4] == 4'd0);
         w_code[i] = (w_lead && i != 0) ? BLANK_CODE : w_shadow[4*i +: 4];
`else
         w_code[i] = w_shadow[4*i +: 4];
`endif
      end
   end
   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_rom
      digit_5x7_rom u_rom (
         .i_code   (w_code[d]),
         .i_row    (r_row),
         .o_pixels (w_pattern[GLYPH_COLS*d +: GLYPH_COLS])
      );
   end
   hc595_shifter #(
      .WIDTH   (NB),
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk          (clk),
      .rst          (rst),
      .i_load       (w_fetch),
      .i_data       (w_pattern),
      .o_ser_data   (ser_data),
      .o_ser_clk    (ser_clk),
      .o_ser_latch  (ser_latch),
      .o_shift_done (w_shift_done),
      .o_done       (w_done)
   );
endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Row-multiplexed driver for the 7-row LED dot-matrix digit display. It captures a packed BCD word and walks rows 0–6. For each row it looks up the glyph row of every digit through `digit_5x7_rom` instances, then serialises the concatenated pixels into an external 74HC595-style shift-register chain. It latches the chain, then lights the matching row driver for a fixed dwell time. The block sits between the value source (counter/controller logic) and the board pins.

## Interface
- `NUM_DIGITS`, default 4: number of displayed digits.
- `CLK_DIV`, default 4: serial-clock half-period in `clk` cycles (≥1).
- `ROW_DWELL`, default 2000: cycles each row stays lit (≥1).
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `digits_in`, input, 4·NUM_DIGITS: packed BCD; `[3:0]` is digit 0, the rightmost digit.
- `load`, input, 1: one-cycle strobe that captures `digits_in`.
- `ser_data`, output, 1: serial pixel data.
- `ser_clk`, output, 1: shift clock; the chain samples on the rising edge.
- `ser_latch`, output, 1: storage-register latch, active high.
- `row_sel`, output, 7: one-hot row enable, active high; bit r drives row r.
- `frame_done`, output, 1: one-cycle pulse at the end of row 6 dwell.

## Operation
- Storage:
  - `pend` register, `pend_valid` flag, and `shadow` digits register.
  - `load` writes `pend` and sets `pend_valid`; the last load wins.
- FSM states: FETCH → SHIFT → LATCH → DWELL → FETCH.
- FETCH, 1 cycle:
  - If row==0 and `pend_valid`: `shadow` ← `pend` and `pend_valid` clears.
  - A `load` in this same cycle bypasses: its value goes directly to `shadow` and `pend_valid` stays 0.
  - The 7·NUM_DIGITS-bit shift register loads with the ROM row of each `shadow` digit at the current row.
- SHIFT: 7·NUM_DIGITS bits, in order:
  - First bit: digit NUM_DIGITS-1, `pixel_row[6]`.
  - Last bit: digit 0, `pixel_row[0]`.
- LATCH: `ser_latch` high for CLK_DIV cycles.
- DWELL: `row_sel` = 1<<row for ROW_DWELL cycles. At the end:
  - Row increments.
  - Row 6 wraps to 0 and `frame_done` pulses in the last DWELL cycle.
- Blanking: `row_sel` = 0 in FETCH, SHIFT and LATCH, so no ghosting while the chain changes.
- Digit codes 10–15 render blank (all-zero glyph).

## Timing
- Reset values:
  - All outputs 0.
  - Row 0, `shadow` 0, `pend_valid` 0.
  - The state after reset deasserts is FETCH.
- Mid-operation reset aborts immediately. Outputs are 0 on the cycle after the reset edge, and `ser_clk` never leaves a partial high pulse afterwards.
- Per bit:
  - `ser_clk` is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `ser_data` changes only on the cycle `ser_clk` falls, or on SHIFT entry.
  - `ser_data` is stable for the whole high phase.
- Row period = 1 + 14·NUM_DIGITS·CLK_DIV + CLK_DIV + ROW_DWELL cycles; with defaults, 2229.
- Frame period = 7 × row period.
- `ser_clk` and `ser_data` are 0 outside SHIFT.
- `ser_latch` is never high while `ser_clk` is high.
- A new value is displayed starting at the row-0 FETCH following the load. Latency is at most one frame plus one cycle.

## Configuration
- Macro: `LEDSCAN_LEADING_ZERO_BLANK_EN`.
- Defined:
  - Zero digits to the left of the most significant non-zero digit render blank.
  - Digit 0 always renders.
  - Evaluated on `shadow` in FETCH.
- Undefined: every digit renders, including leading zeros.

## Structure
- Package `led_scan_pkg`:
  - Constants GLYPH_ROWS=7 and GLYPH_COLS=7.
  - FSM state encoding.
  - BLANK_CODE=4'hF.
- Sub-modules:
  - NUM_DIGITS `digit_5x7_rom` instances, sharing the row index.
  - One natural sub-module, `hc595_shifter`: parallel load, CLK_DIV-paced serialisation, latch pulse, and a `done` handshake to the FSM.

## Test plan
- Reset timing: reset held 5 cycles, then released.
  - All outputs 0 during reset.
  - The first `ser_clk` rise occurs exactly CLK_DIV+1 cycles after release.
- Row 0 serial stream: load 0x1234, then observe the row 0 stream after the next frame boundary.
  - Expected 28 bits: 0001000 0011100 0011100 0000100.
  - One `ser_latch` pulse, then `row_sel`=0000001 for 2000 cycles.
- Frame cadence: free-running with defaults.
  - `row_sel` cycles bits 0→6.
  - `frame_done` pulses every 15603 cycles.
  - `row_sel` is 0 outside DWELL.
- Load semantics:
  - Two loads mid-frame, 0x1111 then 0x9999: only 0x9999 is displayed, from the next row-0 FETCH.
  - A load coincident with the row-0 FETCH is displayed in that same frame.
- Leading-zero blanking: digits 0x0070, row 0.
  - With the macro defined, the digit 3 and digit 2 fields (bits 1–14) are all 0.
  - With the macro undefined, both fields are 0011100.
  - Code 0xA in any position always yields 0000000.
- Reset mid-SHIFT: assert reset in the 10th bit.
  - The next cycle has all outputs 0.
  - After release the full row 0 stream restarts from its first bit.
